mux8_rr_arbiter: RTL and testbench

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

---
 rtl/mux8_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Eight-lane round-robin arbiter/mux: grants one requester at a time, holds the
// registered data until the downstream accepts it, then acks the winning lane.
module mux8_rr_arbiter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    req,
    input  logic [DW-1:0] X0,
    input  logic [DW-1:0] X1,
    input  logic [DW-1:0] X2,
    input  logic [DW-1:0] X3,
    input  logic [DW-1:0] X4,
    input  logic [DW-1:0] X5,
    input  logic [DW-1:0] X6,
    input  logic [DW-1:0] X7,
    input  logic          out_ready,
    output logic [2:0]    sel,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic [7:0]    ack,
    output logic [7:0]    xfer_cnt
);

    // state | meaning
    // IDLE  | no transfer held; arbitrate among req on the next edge
    // BUSY  | granted lane's data held on out_data until out_ready
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [7:0]    ack_q, ack_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [2:0]    last_q, last_d;

    logic [DW-1:0] lane_data [8];
    logic [2:0]    winner;
    logic [2:0]    cand;
    logic          found;

    assign lane_data[0] = X0;
    assign lane_data[1] = X1;
    assign lane_data[2] = X2;
    assign lane_data[3] = X3;
    assign lane_data[4] = X4;
    assign lane_data[5] = X5;
    assign lane_data[6] = X6;
    assign lane_data[7] = X7;

    // Search upward from last+1; the eighth candidate wraps back to last itself.
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        cand   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = last_q + 3'(k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = 8'd0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = winner;
                    data_d  = lane_data[winner];
                    valid_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 8'd1 << sel_q;
                    last_d  = sel_q;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 8'd0;
            cnt_q   <= 8'd0;
            last_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign ack       = ack_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed and randomized checks of mux8_rr_arbiter against a lane-priority
// reference model that tracks the last served lane and pending transfer.
module tb_mux8_rr_arbiter;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    req;
    logic [DW-1:0] x [8];
    logic          out_ready;
    logic [2:0]    sel;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [7:0]    ack;
    logic [7:0]    xfer_cnt;

    mux8_rr_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .X0(x[0]), .X1(x[1]), .X2(x[2]), .X3(x[3]),
        .X4(x[4]), .X5(x[5]), .X6(x[6]), .X7(x[7]),
        .out_ready(out_ready), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .ack(ack), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model
    logic          m_valid;
    logic [2:0]    m_sel;
    logic [DW-1:0] m_data;
    logic [7:0]    m_ack;
    logic [7:0]    m_cnt;
    int            m_last;
    int            wait_cnt [8];
    logic          prev_valid;
    int            dut_grants [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = requesting lane with the smallest forward distance past last.
    function automatic int pick(input logic [7:0] r, input int last);
        int best, bestd, d;
        best = -1;
        bestd = 99;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
                d = (i - last - 1 + 16) % 8;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step();
        int w;
        m_ack = 8'd0;
        if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_ack = 8'd1 << m_sel;
                m_last = int'(m_sel);
                m_cnt = m_cnt + 8'd1;
            end
        end else if (req != 8'd0) begin
            w = pick(req, m_last);
            m_sel = 3'(w);
            m_data = x[w];
            m_valid = 1'b1;
        end
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({where, ".sel"}, 32'(sel), 32'(m_sel));
        chk({where, ".out_data"}, 32'(out_data), 32'(m_data));
        chk({where, ".ack"}, 32'(ack), 32'(m_ack));
        chk({where, ".xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) if (!req[i]) wait_cnt[i] = 0;
        if (out_valid && !prev_valid) begin
            dut_grants.push_back(int'(sel));
            for (int i = 0; i < 8; i++) begin
                if (i == int'(sel)) wait_cnt[i] = 0;
                else if (req[i]) begin
                    wait_cnt[i]++;
                    chk($sformatf("fair_lane%0d", i), 32'(wait_cnt[i] <= 7), 32'd1);
                end
            end
        end
        prev_valid = out_valid;
        check_outputs("cyc");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0; m_sel = 3'd0; m_data = '0; m_ack = 8'd0; m_cnt = 8'd0; m_last = 7;
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        prev_valid = 1'b0;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req = 8'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) x[i] = '0;

        // reset state
        do_reset();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_cnt", 32'(xfer_cnt), 32'd0);

        // single request on lane 2
        req = 8'b0000_0100; x[2] = 4'hA; out_ready = 1'b1;
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_sel", 32'(sel), 32'd2);
        chk("single_data", 32'(out_data), 32'hA);
        req = 8'd0;
        tick();
        chk("single_ack", 32'(ack), 32'h04);
        chk("single_cnt", 32'(xfer_cnt), 32'd1);
        tick();
        chk("single_ack_clear", 32'(ack), 32'h00);

        // round robin with all lanes requesting
        do_reset();
        for (int i = 0; i < 8; i++) x[i] = 4'(i + 3);
        req = 8'hFF; out_ready = 1'b1;
        dut_grants.delete();
        for (int n = 0; n < 18; n++) tick();
        chk("rr_count", 32'(dut_grants.size()), 32'd9);
        for (int k = 0; k < dut_grants.size() && k < 9; k++)
            chk($sformatf("rr_grant%0d", k), 32'(dut_grants[k]), 32'(k % 8));
        chk("rr_cnt", 32'(xfer_cnt), 32'd9);
        req = 8'd0;
        tick();

        // backpressure on lane 5
        req = 8'b0010_0000; x[5] = 4'h3; out_ready = 1'b0;
        tick();
        chk("bp_grant_sel", 32'(sel), 32'd5);
        x[5] = 4'hC;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("bp_data", 32'(out_data), 32'h3);
            chk("bp_sel", 32'(sel), 32'd5);
            chk("bp_ack", 32'(ack), 32'h00);
        end
        req = 8'd0; out_ready = 1'b1;
        tick();
        chk("bp_ack_pulse", 32'(ack), 32'h20);
        tick();
        chk("bp_ack_once", 32'(ack), 32'h00);

        // wrap and skip: serve lane 6, then lanes 0 and 1 request
        req = 8'b0100_0000;
        tick(); tick();
        req = 8'b0000_0011;
        tick();
        chk("wrap_first", 32'(sel), 32'd0);
        tick();
        tick();
        chk("wrap_second", 32'(sel), 32'd1);
        tick();
        req = 8'd0;
        tick();

        // reset mid-transfer
        do_reset();
        req = 8'b0000_0001; out_ready = 1'b0;
        tick();
        chk("midrst_busy", 32'(out_valid), 32'd1);
        do_reset();
        req = 8'd0;
        tick(); tick();
        chk("midrst_cnt", 32'(xfer_cnt), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);

        // 256 transfers wrap the counter
        do_reset();
        req = 8'hFF; out_ready = 1'b1;
        for (int n = 0; n < 512; n++) tick();
        chk("wrap_cnt", 32'(xfer_cnt), 32'd0);
        chk("wrap_valid", 32'(out_valid), 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            req = 8'($urandom) & 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) x[i] = DW'($urandom);
            tick();
            if (n == 1500) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
